// File: rtl/conv_mem_loader.sv
// Memory-read engine: fetches a weight kernel or input image over a pipelined read port
// into the weight/image buffers. Optional running checksum under `LOADER_CKSUM_EN.
module conv_mem_loader #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned WEIGHT_WORDS = 9,
  parameter int unsigned IMG_WORDS    = 784,
  parameter int unsigned WEIGHT_BASE  = 0,
  parameter int unsigned IMG_BASE     = 1024,
  parameter int unsigned MAX_OUT      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_read_enable,
  input  logic              i_img_weight_sel,
  output logic              o_finish_read,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wbuf_we,
  output logic              o_ibuf_we,
  output logic [ADDR_W-1:0] o_buf_waddr,
  output logic [DATA_W-1:0] o_buf_wdata
`ifdef LOADER_CKSUM_EN
  ,
  output logic [15:0]       o_cksum
`endif
);

  localparam int unsigned OUT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone,
    StWaitLow,
    StAbort
  } state_e;

  state_e              r_state;
  logic                r_sel;
  logic [ADDR_W-1:0]   r_n;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_issued;
  logic [ADDR_W-1:0]   r_received;
  logic [OUT_W-1:0]    r_outstanding;
  logic                r_finish;
  logic                r_busy;
  logic                r_wbuf_we;
  logic                r_ibuf_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_start;
  logic                w_loading;
  logic                w_abort;
  logic                w_req;
  logic                w_fire;
  logic                w_resp;
  logic                w_accept;
  logic [OUT_W-1:0]    w_out_d;
  logic [ADDR_W-1:0]   w_issued_d;

  assign w_start    = (r_state == StIdle) && i_read_enable;
  assign w_loading  = (r_state == StIssue) || (r_state == StDrain);
  assign w_abort    = w_loading && !i_read_enable;
  // Request drops combinationally on abort so no grant can land after read_enable falls.
  assign w_req      = (r_state == StIssue) && i_read_enable && (r_outstanding < OUT_W'(MAX_OUT));
  assign w_fire     = w_req && i_mem_gnt;
  assign w_resp     = i_mem_rvalid && (r_outstanding != '0);
  assign w_accept   = w_resp && w_loading && !w_abort;
  assign w_issued_d = r_issued + ADDR_W'(w_fire);

  always_comb begin
    w_out_d = r_outstanding;
    if (w_fire && !w_resp) begin
      w_out_d = r_outstanding + OUT_W'(1);
    end else if (!w_fire && w_resp) begin
      w_out_d = r_outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_sel         <= 1'b0;
      r_n           <= '0;
      r_base        <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
      r_finish      <= 1'b0;
      r_busy        <= 1'b0;
      r_wbuf_we     <= 1'b0;
      r_ibuf_we     <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
    end else begin
      r_outstanding <= w_out_d;
      r_issued      <= w_issued_d;
      r_finish      <= 1'b0;
      r_wbuf_we     <= w_accept && r_sel;
      r_ibuf_we     <= w_accept && !r_sel;
      if (w_accept) begin
        r_waddr    <= r_received;
        r_wdata    <= i_mem_rdata;
        r_received <= r_received + ADDR_W'(1);
      end
      case (r_state)
        StIdle: begin
          if (i_read_enable) begin
            r_sel      <= i_img_weight_sel;
            r_n        <= i_img_weight_sel ? ADDR_W'(WEIGHT_WORDS) : ADDR_W'(IMG_WORDS);
            r_base     <= i_img_weight_sel ? ADDR_W'(WEIGHT_BASE) : ADDR_W'(IMG_BASE);
            r_issued   <= '0;
            r_received <= '0;
            r_busy     <= 1'b1;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          if (w_abort) begin
            r_state <= StAbort;
          end else if (w_issued_d == r_n) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_abort) begin
            r_state <= StAbort;
          end else if (r_received == r_n) begin
            r_finish <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= StDone;
          end
        end
        StDone: begin
          r_state <= StWaitLow;
        end
        StWaitLow: begin
          // Control lowers read_enable late; re-arm only once it is seen low.
          if (!i_read_enable) begin
            r_state <= StIdle;
          end
        end
        StAbort: begin
          if (w_out_d == '0) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [15:0] r_cksum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cksum <= '0;
    end else if (w_start) begin
      r_cksum <= '0;
    end else if (w_accept) begin
      r_cksum <= r_cksum + 16'(i_mem_rdata);
    end
  end

  assign o_cksum = r_cksum;
`endif

  assign o_finish_read = r_finish;
  assign o_busy        = r_busy;
  assign o_mem_req     = w_req;
  assign o_mem_addr    = r_base + r_issued;
  assign o_wbuf_we     = r_wbuf_we;
  assign o_ibuf_we     = r_ibuf_we;
  assign o_buf_waddr   = r_waddr;
  assign o_buf_wdata   = r_wdata;

endmodule
